// File: rtl/cart_rom_sched.sv
// rtl/cart_rom_sched.sv - arbitrates the shared SDRAM cartridge-ROM read port between the cart mapper and an aux requester
// Cart has priority; aux is forced after STARVE back-to-back cart grants. Reads that never ack return 8'hFF.

module cart_rom_sched #(
  parameter int AW      = 19,
  parameter int TIMEOUT = 15,
  parameter int STARVE  = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] rom_size,
  input  logic          cart_req,
  input  logic [AW-1:0] cart_a,
  output logic [7:0]    cart_do,
  output logic          cart_valid,
  input  logic          aux_req,
  input  logic [AW-1:0] aux_a,
  output logic [7:0]    aux_do,
  output logic          aux_ack,
  output logic          sd_req,
  output logic [AW-1:0] sd_a,
  input  logic          sd_ack,
  input  logic [7:0]    sd_do,
  output logic          busy,
  output logic          timeout_err
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int SW = $clog2(STARVE + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
  localparam logic [AW-1:0] ADDR_ONE   = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [AW-1:0]   mask;
  logic [AW-1:0]   cart_ma;
  logic [AW-1:0]   aux_ma;

  logic            cart_pend;
  logic [AW-1:0]   cart_pa;
  logic            aux_pend;
  logic [AW-1:0]   aux_pa;

  logic            grant_aux;
  logic [SW-1:0]   starve;
  logic [TW-1:0]   timer;

  logic            pick_cart;
  logic            pick_aux;
  logic            done_ack;
  logic            done_tmo;
  logic            done;
  logic            cart_dup;
  logic [7:0]      rd_data;

  // rom_size of zero wraps to an all-ones mask, which disables masking
  always_comb begin
    mask    = rom_size - ADDR_ONE;
    cart_ma = cart_a & mask;
    aux_ma  = aux_a & mask;
  end

  always_comb begin
    pick_cart = cart_pend && !(aux_pend && (starve >= STARVE_MAX));
    pick_aux  = !pick_cart && aux_pend;
    done_ack  = (state == S_WAIT) && sd_ack;
    done_tmo  = (state == S_WAIT) && !sd_ack && (timer == TMO_LAST);
    done      = done_ack || done_tmo;
    rd_data   = done_ack ? sd_do : 8'hFF;
    // A repeat of the in-flight cart address is redundant unless that read finishes on this very edge
    cart_dup  = (state == S_WAIT) && !grant_aux && (cart_ma == sd_a) && !done;
  end

  always_comb begin
    state_nxt = state;
    sd_req    = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (cart_pend || aux_pend) state_nxt = S_ARB;
      end
      S_ARB: begin
        if (pick_cart || pick_aux) state_nxt = S_ISSUE;
        else                       state_nxt = S_IDLE;
      end
      S_ISSUE: begin
        sd_req    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Request capture overrides the grant-time clear, so a same-edge request is never lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cart_pend <= 1'b0;
      cart_pa   <= '0;
      aux_pend  <= 1'b0;
      aux_pa    <= '0;
    end else begin
      if ((state == S_ARB) && pick_cart) cart_pend <= 1'b0;
      if ((state == S_ARB) && pick_aux)  aux_pend  <= 1'b0;
      if (cart_req && !cart_dup) begin
        cart_pend <= 1'b1;
        cart_pa   <= cart_ma;
      end
      if (aux_req) begin
        aux_pend <= 1'b1;
        aux_pa   <= aux_ma;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_aux <= 1'b0;
      sd_a      <= '0;
      starve    <= '0;
    end else if ((state == S_ARB) && (pick_cart || pick_aux)) begin
      grant_aux <= pick_aux;
      sd_a      <= pick_aux ? aux_pa : cart_pa;
      if (pick_aux || !aux_pend)  starve <= '0;
      else if (starve < STARVE_MAX) starve <= starve + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer       <= '0;
      cart_do     <= 8'h00;
      cart_valid  <= 1'b0;
      aux_do      <= 8'h00;
      aux_ack     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cart_valid <= 1'b0;
      aux_ack    <= 1'b0;
      if (state == S_ISSUE) timer <= '0;
      if ((state == S_WAIT) && !done) timer <= timer + TW'(1);
      if (done) begin
        if (grant_aux) begin
          aux_do  <= rd_data;
          aux_ack <= 1'b1;
        end else begin
          cart_do    <= rd_data;
          cart_valid <= 1'b1;
        end
      end
      if (done_tmo) timeout_err <= 1'b1;
    end
  end

endmodule

// File: doc/cart_rom_sched.md
Name: cart_rom_sched

Overview:
- Schedules the single SDRAM cartridge-ROM read port between two requesters: the 2600 cart mapper path (primary) and an auxiliary requester (secondary), e.g. the tape/AR loader or an OSD peek.
- Sits between the cart2600-side rom_a/rom_read outputs and the SDRAM controller.
- Provides address masking, one-deep request buffering per requester, starvation protection and a read timeout.

Parameters:
- AW, 19, ROM byte-address width.
- TIMEOUT, 15, cycles to wait for sd_ack before aborting a read (4-bit counter range).
- STARVE, 4, consecutive cart grants allowed while aux is pending before aux is forced.

Ports:
- clk  in  1  master clock.
- reset_n  in  1  asynchronous, active-low reset.
- rom_size  in  AW  ROM image size in bytes; mask = rom_size-1.
- cart_req  in  1  pulse: cart wants a read.
- cart_a  in  AW  cart address, sampled with cart_req.
- cart_do  out  8  last cart read data.
- cart_valid  out  1  one-cycle pulse when cart_do updates.
- aux_req  in  1  pulse: aux wants a read.
- aux_a  in  AW  aux address, sampled with aux_req.
- aux_do  out  8  last aux read data.
- aux_ack  out  1  one-cycle pulse when aux_do updates.
- sd_req  out  1  one-cycle read strobe to SDRAM.
- sd_a  out  AW  SDRAM address, held from sd_req until completion.
- sd_ack  in  1  one-cycle pulse: sd_do valid.
- sd_do  in  8  SDRAM read data.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset (async assert, sync deassert use): all outputs 0, pending flags clear, starve counter 0, state IDLE.
- Capture: cart_req latches cart_pend=1 and cart_pa=cart_a&mask the same edge. A new cart_req while already pending overwrites the address; newest wins, no queue. aux is identical, with its own aux_pend/aux_pa.
- Capture ignores state: a request arriving while a read is in flight is held until the next arbitration.
- FSM states:
  - IDLE: if any pend, go to ARB.
  - ARB: pick the winner.
    - Cart wins if cart_pend and not (aux_pend and starve>=STARVE).
    - Otherwise aux wins if aux_pend.
    - Clear the winner's pend flag, latch sd_a, go to ISSUE.
  - ISSUE: sd_req=1 for exactly one cycle, go to WAIT, timer=0.
  - WAIT:
    - On sd_ack: deliver sd_do to the winner's do register and pulse its valid/ack next cycle, then go to IDLE.
    - If timer reaches TIMEOUT without sd_ack: deliver 8'hFF, pulse valid/ack, set timeout_err, go to IDLE.
- Latency: request to sd_req is 3 cycles (capture, IDLE->ARB, ARB->ISSUE). sd_ack to valid/ack is 1 cycle.
- Cart dedup: if a cart_req arrives in WAIT with masked address equal to the in-flight cart address, it is dropped and cart_pend is not set.
- Same-edge cart_req and completion for cart: the new request is kept pending. It is not lost and not merged.
- Starve counter:
  - Increments (saturating at STARVE) on each cart grant made while aux_pend=1.
  - Resets to 0 on an aux grant.
  - Resets to 0 when aux_pend=0 at ARB.
- sd_ack outside WAIT: ignored.
- Mask: mask = rom_size - 1 (AW-bit wrap). rom_size=0 gives mask all-ones, i.e. no masking.
- reset_n asserted mid-read: abort immediately, no valid/ack pulse. The SDRAM may still ack later; that ack is ignored.

Test Plan:
- Basic cart read: rom_size=0x1000, cart_req with cart_a=0x1234 → sd_req 3 cycles later with sd_a=0x0234. sd_ack with sd_do=0xA5 → cart_valid one cycle later, cart_do=0xA5, busy returns to 0.
- Priority: cart_req and aux_req on the same edge → cart served first (sd_a=cart). aux is issued right after cart completes. aux_ack occurs with its data.
- Starvation: aux_req held pending while cart_req pulses every 6 cycles → after 4 cart grants the next grant goes to aux and the starve counter returns to 0.
- Overwrite/dedup:
  - Two cart_req with 0x100 then 0x200 during WAIT → only 0x200 is issued next.
  - A cart_req repeating the in-flight address → no extra sd_req.
- Timeout: sd_ack never asserted → after 15 WAIT cycles, cart_valid pulses with cart_do=0xFF, timeout_err=1. The next request is served normally and timeout_err stays 1.
- Reset mid-WAIT: reset_n low during WAIT → busy, cart_valid and sd_req are 0 immediately. A late sd_ack after release produces no pulse.
